// File: rtl/alu_instr_encoder_if.sv
// Request and issue ports of the ALU instruction encoder.
// master: the requester / consumer side.  slave: the encoder.
interface alu_instr_encoder_if;
    logic        req_valid;
    logic        req_ready;
    logic [3:0]  req_op;
    logic [1:0]  req_rn;
    logic [1:0]  req_rm;
    logic [1:0]  req_rx;
    logic [1:0]  req_sh;
    logic [1:0]  req_cin;
    logic [3:0]  req_amt;
    logic [8:0]  req_imm;
    logic        req_wide;
    logic        instr_valid;
    logic        instr_ready;
    logic [15:0] instr;

    modport master (
        output req_valid, req_op, req_rn, req_rm, req_rx, req_sh, req_cin,
               req_amt, req_imm, req_wide, instr_ready,
        input  req_ready, instr_valid, instr
    );

    modport slave (
        input  req_valid, req_op, req_rn, req_rm, req_rx, req_sh, req_cin,
               req_amt, req_imm, req_wide, instr_ready,
        output req_ready, instr_valid, instr
    );
endinterface

// File: rtl/alu_instr_encoder.sv
// Packs ALU operation requests into 16-bit instruction words and queues them
// for the decoder. Wide ADR/SBR requests become a LOW word followed by a
// carry-chained HIGH word.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | accepting requests while the FIFO has room
// HIGH  | LOW word of a wide op queued; HIGH word waits for a free slot
module alu_instr_encoder #(
    parameter int DEPTH = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    alu_instr_encoder_if.slave bus,
    output logic               err,
    output logic               busy
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    typedef enum logic {
        IDLE = 1'b0,
        HIGH = 1'b1
    } state_t;

    state_t        state;
    logic          hi_sbr;
    logic          hi_rn_msb;
    logic          hi_rm_msb;
    logic [1:0]    hi_rx;
    logic [1:0]    hi_sh;

    logic [15:0]   mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] count;

    logic          not_full;
    logic          accept;
    logic          pop;
    logic          push;
    logic          req_legal;
    logic          wide_req;
    logic [15:0]   req_word;
    logic [15:0]   low_word;
    logic [15:0]   high_word;
    logic [15:0]   push_word;

    function automatic logic [15:0] encode(
        input logic [3:0] op,
        input logic [1:0] rn,
        input logic [1:0] rm,
        input logic [1:0] rx,
        input logic [1:0] sh,
        input logic [1:0] cin,
        input logic [3:0] amt,
        input logic [8:0] imm
    );
        logic [15:0] w;
        w = '0;
        case (op)
            4'd0:  w = {5'b00001, 1'b0, cin, sh, rx, rn, rm};
            4'd1:  w = {4'b0001, rn[0], 2'b00, imm};
            4'd2:  w = {5'b00100, rn, imm};
            4'd3:  w = {5'b00101, 1'b0, cin, sh, rx, rn, rm};
            4'd4:  w = {4'b0011, rn[0], 2'b00, imm};
            4'd5:  w = {5'b01000, rn, imm};
            4'd6:  w = {5'b01001, 1'b0, cin, sh, rx, rn, rm};
            4'd7:  w = {5'b01010, 1'b0, cin, amt, 2'b00, rm};
            4'd8:  w = {5'b01011, 1'b0, cin, amt, 2'b00, rm};
            4'd9:  w = {5'b01100, 1'b0, cin, sh, rx, rn, rm};
            4'd10: w = {5'b01101, 2'b00, imm};
            4'd11: w = {5'b01110, 2'b00, |amt, rn, rm, amt};
            4'd12: w = {5'b01111, 2'b00, |amt, rn, rm, amt};
            default: w = '0;
        endcase
        return w;
    endfunction

    assign not_full        = (count < FULL);
    assign bus.req_ready   = (state == IDLE) & not_full;
    assign bus.instr_valid = (count != '0);
    assign bus.instr       = bus.instr_valid ? mem[rd_ptr] : 16'h0000;
    assign busy            = (state == HIGH) | (count != '0);

    assign accept    = bus.req_valid & bus.req_ready;
    assign pop       = bus.instr_valid & bus.instr_ready;
    assign req_legal = (bus.req_op <= 4'd12);
    assign wide_req  = bus.req_wide & ((bus.req_op == 4'd0) | (bus.req_op == 4'd3));

    assign req_word  = encode(bus.req_op, bus.req_rn, bus.req_rm, bus.req_rx,
                              bus.req_sh, bus.req_cin, bus.req_amt, bus.req_imm);
    // LOW half pairs the even registers with no incoming carry/borrow.
    assign low_word  = encode(bus.req_op, {bus.req_rn[1], 1'b0}, {bus.req_rm[1], 1'b0},
                              bus.req_rx, bus.req_sh, 2'b00, 4'd0, 9'd0);
    // HIGH half pairs the odd registers and chains the LOW half's carry.
    assign high_word = encode(hi_sbr ? 4'd3 : 4'd0, {hi_rn_msb, 1'b1}, {hi_rm_msb, 1'b1},
                              hi_rx, hi_sh, 2'b10, 4'd0, 9'd0);

    // Select what, if anything, enters the FIFO this cycle.
    always_comb begin
        push      = 1'b0;
        push_word = '0;
        if (state == HIGH) begin
            push      = not_full;
            push_word = high_word;
        end else if (accept & req_legal) begin
            push      = 1'b1;
            push_word = wide_req ? low_word : req_word;
        end
    end

    // Sequencer: wide-op state, latched HIGH-word fields and the error pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            hi_sbr    <= 1'b0;
            hi_rn_msb <= 1'b0;
            hi_rm_msb <= 1'b0;
            hi_rx     <= 2'b00;
            hi_sh     <= 2'b00;
            err       <= 1'b0;
        end else begin
            err <= accept & ~req_legal;
            case (state)
                IDLE: begin
                    if (accept & req_legal & wide_req) begin
                        state     <= HIGH;
                        hi_sbr    <= (bus.req_op == 4'd3);
                        hi_rn_msb <= bus.req_rn[1];
                        hi_rm_msb <= bus.req_rm[1];
                        hi_rx     <= bus.req_rx;
                        hi_sh     <= bus.req_sh;
                    end
                end
                HIGH: begin
                    if (not_full) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Instruction FIFO storage, pointers and occupancy.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= push_word;
                wr_ptr      <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end
endmodule

// File: tb/tb_alu_instr_encoder.sv
// Self-checking bench for alu_instr_encoder: directed scenarios plus random
// traffic compared against a queue-based reference model.
module tb_alu_instr_encoder;
    localparam int DEPTH = 4;

    logic clk = 1'b0;
    logic rst_n;
    logic err;
    logic busy;

    alu_instr_encoder_if bus ();

    alu_instr_encoder #(.DEPTH(DEPTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus),
        .err   (err),
        .busy  (busy)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // reference model state
    logic [15:0] q[$];
    bit          m_high;
    logic [15:0] m_hi_word;
    bit          m_err;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Instruction word from the field layout, built by weighted sums.
    function automatic logic [15:0] ref_word(input int op, input int rn, input int rm, input int rx,
                                             input int sh, input int cin, input int amt, input int imm);
        int w;
        w = 0;
        case (op)
            0:  w = 1 * 2048 + cin * 256 + sh * 64 + rx * 16 + rn * 4 + rm;
            3:  w = 5 * 2048 + cin * 256 + sh * 64 + rx * 16 + rn * 4 + rm;
            6:  w = 9 * 2048 + cin * 256 + sh * 64 + rx * 16 + rn * 4 + rm;
            9:  w = 12 * 2048 + cin * 256 + sh * 64 + rx * 16 + rn * 4 + rm;
            7:  w = 10 * 2048 + cin * 256 + amt * 16 + rm;
            8:  w = 11 * 2048 + cin * 256 + amt * 16 + rm;
            2:  w = 4 * 2048 + rn * 512 + imm;
            5:  w = 8 * 2048 + rn * 512 + imm;
            1:  w = 1 * 4096 + (rn % 2) * 2048 + imm;
            4:  w = 3 * 4096 + (rn % 2) * 2048 + imm;
            10: w = 13 * 2048 + imm;
            11: w = 14 * 2048 + (amt != 0 ? 256 : 0) + rn * 64 + rm * 16 + amt;
            12: w = 15 * 2048 + (amt != 0 ? 256 : 0) + rn * 64 + rm * 16 + amt;
            default: w = 0;
        endcase
        return 16'(w);
    endfunction

    task automatic model_reset();
        q.delete();
        m_high = 0;
        m_err  = 0;
    endtask

    task automatic drive_req(input int op, input int rn, input int rm, input int rx, input int sh,
                             input int cin, input int amt, input int imm, input bit wide);
        bus.req_valid = 1'b1;
        bus.req_op    = 4'(op);
        bus.req_rn    = 2'(rn);
        bus.req_rm    = 2'(rm);
        bus.req_rx    = 2'(rx);
        bus.req_sh    = 2'(sh);
        bus.req_cin   = 2'(cin);
        bus.req_amt   = 4'(amt);
        bus.req_imm   = 9'(imm);
        bus.req_wide  = wide;
    endtask

    // Compare all outputs with the model, advance the model across the next
    // rising edge, then wait for the falling edge.
    task automatic step();
        int          sz;
        bit          m_ready;
        bit          acc;
        bit          nerr;
        int          op;
        int          rn;
        int          rm;
        logic [15:0] tmp;
        sz      = q.size();
        m_ready = !m_high && (sz < DEPTH);
        check_eq("req_ready", bus.req_ready, m_ready);
        check_eq("instr_valid", bus.instr_valid, sz != 0);
        check_eq("instr", bus.instr, (sz != 0) ? q[0] : 16'h0000);
        check_eq("busy", busy, m_high || (sz != 0));
        check_eq("err", err, m_err);

        acc  = bus.req_valid && m_ready;
        nerr = 0;
        op   = int'(bus.req_op);
        rn   = int'(bus.req_rn);
        rm   = int'(bus.req_rm);
        if (sz > 0 && bus.instr_ready) tmp = q.pop_front();
        if (m_high) begin
            if (sz < DEPTH) begin
                q.push_back(m_hi_word);
                m_high = 0;
            end
        end else if (acc) begin
            if (op > 12) begin
                nerr = 1;
            end else if (bus.req_wide && (op == 0 || op == 3)) begin
                q.push_back(ref_word(op, (rn / 2) * 2, (rm / 2) * 2, int'(bus.req_rx),
                                     int'(bus.req_sh), 0, 0, 0));
                m_hi_word = ref_word(op, (rn / 2) * 2 + 1, (rm / 2) * 2 + 1, int'(bus.req_rx),
                                     int'(bus.req_sh), 2, 0, 0);
                m_high = 1;
            end else begin
                q.push_back(ref_word(op, rn, rm, int'(bus.req_rx), int'(bus.req_sh),
                                     int'(bus.req_cin), int'(bus.req_amt), int'(bus.req_imm)));
            end
        end
        m_err = nerr;
        @(negedge clk);
    endtask

    task automatic drain();
        bus.req_valid   = 1'b0;
        bus.instr_ready = 1'b1;
        for (int i = 0; i < 12 && (q.size() != 0 || m_high); i++) step();
        check_eq("drained", bus.instr_valid, 1'b0);
        bus.instr_ready = 1'b0;
    endtask

    logic [15:0] obs[$];
    logic [15:0] exp_lo;
    logic [15:0] exp_hi;
    logic        v_before;

    initial begin
        rst_n = 1'b0;
        bus.req_valid   = 1'b0;
        bus.req_op      = '0;
        bus.req_rn      = '0;
        bus.req_rm      = '0;
        bus.req_rx      = '0;
        bus.req_sh      = '0;
        bus.req_cin     = '0;
        bus.req_amt     = '0;
        bus.req_imm     = '0;
        bus.req_wide    = 1'b0;
        bus.instr_ready = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        check_eq("rst_instr_valid", bus.instr_valid, 1'b0);
        check_eq("rst_instr", bus.instr, 16'h0000);
        check_eq("rst_err", err, 1'b0);
        check_eq("rst_busy", busy, 1'b0);
        check_eq("rst_req_ready", bus.req_ready, 1'b1);
        rst_n = 1'b1;
        @(negedge clk);

        // plain ADR
        drive_req(0, 1, 2, 3, 2, 2, 0, 0, 0);
        step();
        bus.req_valid = 1'b0;
        check_eq("adr_valid", bus.instr_valid, 1'b1);
        check_eq("adr_word", bus.instr, 16'h0AB6);
        drain();

        // wide SBR: LOW then HIGH, one cycle of back-pressure
        drive_req(3, 2, 1, 0, 0, 1, 0, 0, 1);
        step();
        bus.req_valid = 1'b0;
        check_eq("wide_ready_lo", bus.req_ready, 1'b0);
        check_eq("wide_low", bus.instr, 16'h2808);
        step();
        check_eq("wide_ready_back", bus.req_ready, 1'b1);
        bus.instr_ready = 1'b1;
        step();
        check_eq("wide_high", bus.instr, 16'h2A0D);
        drain();

        // fill to DEPTH, then a single pop restores ready
        for (int i = 0; i < DEPTH; i++) begin
            drive_req(2 + (i % 2) * 3, i, 0, 0, 0, 0, 0, 17 * i + 3, 0);
            step();
        end
        bus.req_valid = 1'b0;
        check_eq("full_ready", bus.req_ready, 1'b0);
        bus.instr_ready = 1'b1;
        step();
        bus.instr_ready = 1'b0;
        check_eq("pop_ready", bus.req_ready, 1'b1);
        drain();

        // wide ADR landing in the last slot, HIGH held until space
        for (int i = 0; i < 3; i++) begin
            drive_req(11, i, 3 - i, 0, 0, 0, i + 1, 0, 0);
            step();
        end
        drive_req(0, 1, 3, 2, 1, 3, 0, 0, 1);
        step();
        bus.req_valid = 1'b0;
        step();
        check_eq("hold_busy", busy, 1'b1);
        check_eq("hold_ready", bus.req_ready, 1'b0);
        check_eq("hold_count_full", bus.instr_valid, 1'b1);
        exp_lo = ref_word(0, 0, 2, 2, 1, 0, 0, 0);
        exp_hi = ref_word(0, 1, 3, 2, 1, 2, 0, 0);
        obs.delete();
        bus.instr_ready = 1'b1;
        for (int i = 0; i < 12 && (q.size() != 0 || m_high); i++) begin
            if (bus.instr_valid) obs.push_back(bus.instr);
            step();
        end
        check_eq("order_count", obs.size(), 5);
        if (obs.size() == 5) begin
            check_eq("order_low", obs[3], exp_lo);
            check_eq("order_high", obs[4], exp_hi);
        end
        drain();

        // illegal op
        v_before = bus.instr_valid;
        drive_req(14, 1, 1, 1, 1, 1, 1, 1, 0);
        step();
        bus.req_valid = 1'b0;
        check_eq("illegal_err", err, 1'b1);
        check_eq("illegal_nopush", bus.instr_valid, v_before);
        step();
        check_eq("illegal_err_pulse", err, 1'b0);

        // reset while HIGH with two entries queued
        drive_req(6, 1, 2, 0, 0, 0, 0, 0, 0);
        step();
        drive_req(3, 3, 2, 1, 3, 0, 0, 0, 1);
        step();
        bus.req_valid = 1'b0;
        check_eq("pre_rst_busy", busy, 1'b1);
        rst_n = 1'b0;
        #1;
        check_eq("mid_rst_valid", bus.instr_valid, 1'b0);
        check_eq("mid_rst_busy", busy, 1'b0);
        check_eq("mid_rst_ready", bus.req_ready, 1'b1);
        model_reset();
        #1;
        rst_n = 1'b1;
        drive_req(9, 2, 3, 1, 2, 1, 0, 0, 0);
        step();
        bus.req_valid = 1'b0;
        check_eq("post_rst_word", bus.instr, ref_word(9, 2, 3, 1, 2, 1, 0, 0));
        drain();

        // random traffic
        for (int i = 0; i < 500; i++) begin
            bus.req_valid   = ($urandom_range(0, 3) != 0);
            bus.req_op      = 4'($urandom_range(0, 15));
            bus.req_rn      = 2'($urandom);
            bus.req_rm      = 2'($urandom);
            bus.req_rx      = 2'($urandom);
            bus.req_sh      = 2'($urandom);
            bus.req_cin     = 2'($urandom);
            bus.req_amt     = 4'($urandom);
            bus.req_imm     = 9'($urandom);
            bus.req_wide    = ($urandom_range(0, 1) != 0);
            bus.instr_ready = ($urandom_range(0, 2) != 0);
            step();
        end
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
